race_lap_controller: RTL

Sequences the race datapath once the game FSM reaches RACING. It runs the race clock, validates track checkpoints in order, counts laps, and raises is_game_end back to the game state machine when the final lap completes or the clock saturates. It consumes the 3-bit game state and checkpoint pulses from track logic, and drives the HUD time/lap fields.

---
 rtl/race_pkg.sv | 28 ++
 rtl/race_lap_controller_tick_gen.sv | 27 ++
 rtl/race_lap_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/race_pkg.sv
// Shared race constants: game-state encoding used by the game FSM, race-clock
// field limits, lap-timer width and the checkpoint event classification.
package race_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTING   = 3'd1,
        SYNCING   = 3'd2,
        COUNTDOWN = 3'd3,
        RACING    = 3'd4,
        PAUSE     = 3'd5,
        FINISH    = 3'd6
    } game_state_e;

    typedef enum logic [2:0] {
        CK_NONE,
        CK_ADVANCE,
        CK_LAP,
        CK_LINGER,
        CK_WRONG
    } ckpt_evt_e;

    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 99;
    localparam int LAP_W   = 20;

endpackage

// File: rtl/race_lap_controller_tick_gen.sv
// Enable-gated prescaler producing a one-cycle race-clock tick every DIV
// enabled cycles; the count holds while disabled and clears on i_clr.
module race_tick_gen #(
    parameter int DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/race_lap_controller.sv
// Race clock, in-order checkpoint validation and lap counting for the RACING phase.
// Optional best-lap tracking is enabled by defining RACE_BEST_LAP_EN.
module race_lap_controller
    import race_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int TICK_HZ  = 100,
    parameter int NUM_LAPS = 3,
    parameter int NUM_CKPT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    input  logic             ckpt_hit,
    input  logic [3:0]       ckpt_id,
    output logic [6:0]       race_min,
    output logic [5:0]       race_sec,
    output logic [6:0]       race_cs,
    output logic [3:0]       lap_cnt,
    output logic [3:0]       next_ckpt,
    output logic [LAP_W-1:0] lap_time,
    output logic             lap_done,
    output logic             wrong_ckpt,
    output logic             is_game_end
`ifdef RACE_BEST_LAP_EN
    ,
    output logic [LAP_W-1:0] best_lap,
    output logic             new_best
`endif
);

    localparam logic [LAP_W-1:0] LT_MAX    = '1;
    localparam logic [3:0]       CKPT_LAST = 4'(NUM_CKPT - 1);
    localparam logic [3:0]       LAPS_END  = 4'(NUM_LAPS);

    logic [6:0]       r_race_min;
    logic [5:0]       r_race_sec;
    logic [6:0]       r_race_cs;
    logic [3:0]       r_lap_cnt;
    logic [3:0]       r_next_ckpt;
    logic [LAP_W-1:0] r_lap_time;
    logic [LAP_W-1:0] r_lap_timer;
    logic             r_lap_done;
    logic             r_wrong_ckpt;
    logic             r_game_end;
`ifdef RACE_BEST_LAP_EN
    logic [LAP_W-1:0] r_best_lap;
    logic             r_new_best;
`endif

    logic             w_clear;
    logic             w_active;
    logic             w_tick;
    logic             w_at_max;
    logic [3:0]       w_next_inc;
    logic [3:0]       w_last_ckpt;
    logic [LAP_W-1:0] w_lt_inc;
    ckpt_evt_e        w_evt;

    assign w_clear     = (state == IDLE) || (state == COUNTDOWN);
    assign w_active    = (state == RACING) && !r_game_end;
    assign w_at_max    = (r_race_min == 7'(MIN_MAX)) && (r_race_sec == 6'(SEC_MAX))
                         && (r_race_cs == 7'(CS_MAX));
    assign w_next_inc  = (r_next_ckpt == CKPT_LAST) ? '0 : r_next_ckpt + 4'd1;
    // The last passed id is always the one just before the expected one.
    assign w_last_ckpt = (r_next_ckpt == '0) ? CKPT_LAST : r_next_ckpt - 4'd1;
    assign w_lt_inc    = (r_lap_timer == LT_MAX) ? LT_MAX : r_lap_timer + 1'b1;

    race_tick_gen #(
        .DIV(CLK_HZ / TICK_HZ)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clear),
        .i_en   (w_active),
        .o_tick (w_tick)
    );

    always_comb begin
        w_evt = CK_NONE;
        if (w_active && ckpt_hit) begin
            if ((ckpt_id == r_next_ckpt) && (r_next_ckpt != '0)) begin
                w_evt = CK_ADVANCE;
            end else if ((ckpt_id == '0) && (r_next_ckpt == '0)) begin
                w_evt = CK_LAP;
            end else if (ckpt_id == w_last_ckpt) begin
                w_evt = CK_LINGER;
            end else begin
                w_evt = CK_WRONG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_race_min   <= '0;
            r_race_sec   <= '0;
            r_race_cs    <= '0;
            r_lap_cnt    <= '0;
            r_next_ckpt  <= 4'd1;
            r_lap_time   <= '0;
            r_lap_timer  <= '0;
            r_lap_done   <= 1'b0;
            r_wrong_ckpt <= 1'b0;
            r_game_end   <= 1'b0;
`ifdef RACE_BEST_LAP_EN
            r_best_lap   <= '1;
            r_new_best   <= 1'b0;
`endif
        end else begin
            r_lap_done   <= 1'b0;
            r_wrong_ckpt <= 1'b0;
`ifdef RACE_BEST_LAP_EN
            r_new_best   <= 1'b0;
`endif
            if (w_active) begin
                if (w_at_max) begin
                    r_game_end <= 1'b1;
                end else if (w_tick) begin
                    if (r_race_cs == 7'(CS_MAX)) begin
                        r_race_cs <= '0;
                        if (r_race_sec == 6'(SEC_MAX)) begin
                            r_race_sec <= '0;
                            r_race_min <= r_race_min + 7'd1;
                        end else begin
                            r_race_sec <= r_race_sec + 6'd1;
                        end
                    end else begin
                        r_race_cs <= r_race_cs + 7'd1;
                    end
                end

                if (w_tick) begin
                    r_lap_timer <= w_lt_inc;
                end

                // A lap completion overrides the tick update above and restarts
                // the timer, counting the coincident tick into the new lap.
                case (w_evt)
                    CK_ADVANCE: r_next_ckpt <= w_next_inc;
                    CK_LAP: begin
                        r_lap_time  <= r_lap_timer;
                        r_lap_timer <= LAP_W'(w_tick);
                        r_lap_cnt   <= r_lap_cnt + 4'd1;
                        r_lap_done  <= 1'b1;
                        r_next_ckpt <= 4'd1;
                        if ((r_lap_cnt + 4'd1) == LAPS_END) begin
                            r_game_end <= 1'b1;
                        end
`ifdef RACE_BEST_LAP_EN
                        if (r_lap_timer < r_best_lap) begin
                            r_best_lap <= r_lap_timer;
                            r_new_best <= 1'b1;
                        end
`endif
                    end
                    CK_WRONG: r_wrong_ckpt <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign race_min    = r_race_min;
    assign race_sec    = r_race_sec;
    assign race_cs     = r_race_cs;
    assign lap_cnt     = r_lap_cnt;
    assign next_ckpt   = r_next_ckpt;
    assign lap_time    = r_lap_time;
    assign lap_done    = r_lap_done;
    assign wrong_ckpt  = r_wrong_ckpt;
    assign is_game_end = r_game_end;
`ifdef RACE_BEST_LAP_EN
    assign best_lap    = r_best_lap;
    assign new_best    = r_new_best;
`endif

endmodule
